// File: rtl/instruction_fetch.sv
// instruction_fetch: LEGv8 fetch stage, PC and IF/ID pipeline register.
// Define IFETCH_ALIGN_CHECK_EN for branch-target alignment faults.
module instruction_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter logic [31:0] NOP_INSN = 32'hD503201F
) (
  input  logic        CLK,
  input  logic        RESET,
  output logic        IMEM_REQ_VALID,
  input  logic        IMEM_REQ_READY,
  output logic [63:0] IMEM_ADDR,
  input  logic        IMEM_RSP_VALID,
  input  logic [31:0] IMEM_RSP_DATA,
  input  logic        STALL,
  input  logic        FLUSH,
  input  logic        BRANCH_TAKEN,
  input  logic [63:0] BRANCH_TARGET,
  output logic [31:0] IF_ID_INSTRUCTION,
  output logic [63:0] IF_ID_PC,
`ifdef IFETCH_ALIGN_CHECK_EN
  output logic        IF_ID_VALID,
  output logic        IF_ID_MISALIGN
`else
  output logic        IF_ID_VALID
`endif
);

  typedef enum logic [1:0] {
    REQ,
    WAIT,
    HOLD,
    FAULT
  } state_t;

  state_t      state, state_n;
  logic [63:0] pc, pc_n;
  logic [31:0] buf_q, buf_n;
  logic        discard, discard_n;
  logic        req_valid, req_valid_n;
  logic [31:0] insn, insn_n;
  logic [63:0] id_pc, id_pc_n;
  logic        id_valid, id_valid_n;
  logic        misalign, misalign_n;
  logic        hs;
  logic        load;
  logic [31:0] load_data;
  logic [63:0] target;
  logic        bad_target;

`ifdef IFETCH_ALIGN_CHECK_EN
  assign target     = BRANCH_TARGET;
  assign bad_target = |BRANCH_TARGET[1:0];
`else
  logic unused_tgt;
  assign unused_tgt = ^BRANCH_TARGET[1:0];
  assign target     = {BRANCH_TARGET[63:2], 2'b00};
  assign bad_target = 1'b0;
`endif

  assign hs = (state == REQ) && req_valid && IMEM_REQ_READY;

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    buf_n      = buf_q;
    discard_n  = discard;
    insn_n     = insn;
    id_pc_n    = id_pc;
    id_valid_n = id_valid;
    misalign_n = misalign;
    load       = 1'b0;
    load_data  = IMEM_RSP_DATA;

    unique case (state)
      REQ: begin
        if (IMEM_RSP_VALID && discard) discard_n = 1'b0;
        if (hs) state_n = WAIT;
      end
      WAIT: begin
        if (IMEM_RSP_VALID) begin
          if (discard) begin
            discard_n = 1'b0;
            state_n   = REQ;
          end else if (!STALL) begin
            load    = 1'b1;
            state_n = REQ;
          end else begin
            buf_n   = IMEM_RSP_DATA;
            state_n = HOLD;
          end
        end
      end
      HOLD: begin
        if (!STALL) begin
          load      = 1'b1;
          load_data = buf_q;
          state_n   = REQ;
        end
      end
      FAULT: begin
        if (IMEM_RSP_VALID && discard) discard_n = 1'b0;
      end
      default: state_n = REQ;
    endcase

    // A response landing with FLUSH belongs to the new path and is kept
    if (load) begin
      insn_n     = load_data;
      id_pc_n    = pc;
      id_valid_n = 1'b1;
      misalign_n = 1'b0;
      pc_n       = pc + 64'd4;
    end else if (FLUSH) begin
      insn_n     = NOP_INSN;
      id_pc_n    = 64'h0;
      id_valid_n = 1'b0;
      misalign_n = 1'b0;
    end

    if (BRANCH_TAKEN) begin
      pc_n       = target;
      insn_n     = NOP_INSN;
      id_pc_n    = 64'h0;
      id_valid_n = 1'b0;
      misalign_n = 1'b0;
      unique case (state)
        REQ: begin
          state_n = hs ? WAIT : REQ;
          if (hs) discard_n = 1'b1;
        end
        WAIT: begin
          // a response this very cycle is the stale one: nothing left in flight
          state_n   = IMEM_RSP_VALID ? REQ : WAIT;
          discard_n = !IMEM_RSP_VALID;
        end
        HOLD:    state_n = REQ;
        FAULT:   state_n = REQ;
        default: state_n = REQ;
      endcase
      if (bad_target) begin
        state_n    = FAULT;
        id_pc_n    = target;
        id_valid_n = 1'b1;
        misalign_n = 1'b1;
      end
    end

    // no new request while a stale response is still owed
    req_valid_n = (state_n == REQ) && !discard_n;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= REQ;
      pc        <= RESET_PC;
      buf_q     <= 32'h0;
      discard   <= 1'b0;
      req_valid <= 1'b0;
      insn      <= NOP_INSN;
      id_pc     <= 64'h0;
      id_valid  <= 1'b0;
      misalign  <= 1'b0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      buf_q     <= buf_n;
      discard   <= discard_n;
      req_valid <= req_valid_n;
      insn      <= insn_n;
      id_pc     <= id_pc_n;
      id_valid  <= id_valid_n;
      misalign  <= misalign_n;
    end
  end

  assign IMEM_REQ_VALID    = req_valid;
  assign IMEM_ADDR         = pc;
  assign IF_ID_INSTRUCTION = insn;
  assign IF_ID_PC          = id_pc;
  assign IF_ID_VALID       = id_valid;

`ifdef IFETCH_ALIGN_CHECK_EN
  assign IF_ID_MISALIGN = misalign;
`else
  logic unused_mis;
  assign unused_mis = misalign;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed checks of the fetch stage.
// Covers reset, stall buffering, redirect, backpressure, wrap, flush.
module tb_instruction_fetch;

  localparam logic [31:0] NOP = 32'hD503201F;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        stall;
  logic        flush;
  logic        br;
  logic [63:0] br_tgt;
  logic [31:0] id_insn;
  logic [63:0] id_pc;
  logic        id_valid;
`ifdef IFETCH_ALIGN_CHECK_EN
  logic        id_mis;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instruction_fetch dut (
    .CLK               (clk),
    .RESET             (rst),
    .IMEM_REQ_VALID    (req_valid),
    .IMEM_REQ_READY    (req_ready),
    .IMEM_ADDR         (addr),
    .IMEM_RSP_VALID    (rsp_valid),
    .IMEM_RSP_DATA     (rsp_data),
    .STALL             (stall),
    .FLUSH             (flush),
    .BRANCH_TAKEN      (br),
    .BRANCH_TARGET     (br_tgt),
    .IF_ID_INSTRUCTION (id_insn),
    .IF_ID_PC          (id_pc),
`ifdef IFETCH_ALIGN_CHECK_EN
    .IF_ID_VALID       (id_valid),
    .IF_ID_MISALIGN    (id_mis)
`else
    .IF_ID_VALID       (id_valid)
`endif
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // from REQ with a live request: accept, then 1-cycle response
  task automatic fetch(input logic [31:0] d);
    tick();
    rsp_valid = 1'b1;
    rsp_data  = d;
    tick();
    rsp_valid = 1'b0;
  endtask

  task automatic check_ifid(input string tag,
                            input logic [31:0] i,
                            input logic [63:0] p,
                            input logic v);
    check({tag, "_insn"}, {32'h0, id_insn}, {32'h0, i});
    check({tag, "_pc"}, id_pc, p);
    check({tag, "_vld"}, {63'h0, id_valid}, {63'h0, v});
  endtask

  initial begin
    rst       = 1'b1;
    req_ready = 1'b1;
    rsp_valid = 1'b0;
    rsp_data  = 32'h0;
    stall     = 1'b0;
    flush     = 1'b0;
    br        = 1'b0;
    br_tgt    = 64'h0;

    tick();
    check("rst_reqv", {63'h0, req_valid}, 64'h0);
    check("rst_addr", addr, 64'h0);
    check_ifid("rst", NOP, 64'h0, 1'b0);
    rst = 1'b0;
    tick();
    check("post_rst_reqv", {63'h0, req_valid}, 64'h1);

    fetch(32'hF8400020);
    check_ifid("f0", 32'hF8400020, 64'h0, 1'b1);
    check("f0_addr", addr, 64'h4);
    check("f0_reqv", {63'h0, req_valid}, 64'h1);

    tick();
    check("wait_reqv", {63'h0, req_valid}, 64'h0);
    stall     = 1'b1;
    rsp_valid = 1'b1;
    rsp_data  = 32'h8B020020;
    tick();
    rsp_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check_ifid("hold", 32'hF8400020, 64'h0, 1'b1);
      check("hold_addr", addr, 64'h4);
      check("hold_reqv", {63'h0, req_valid}, 64'h0);
      tick();
    end
    check_ifid("hold3", 32'hF8400020, 64'h0, 1'b1);
    stall = 1'b0;
    tick();
    check_ifid("rel", 32'h8B020020, 64'h4, 1'b1);
    check("rel_addr", addr, 64'h8);

    tick();
    br     = 1'b1;
    br_tgt = 64'h100;
    tick();
    br = 1'b0;
    check_ifid("brw", NOP, 64'h0, 1'b0);
    check("brw_addr", addr, 64'h100);
    check("brw_reqv", {63'h0, req_valid}, 64'h0);
    rsp_valid = 1'b1;
    rsp_data  = 32'hDEADBEEF;
    tick();
    rsp_valid = 1'b0;
    check("stale_vld", {63'h0, id_valid}, 64'h0);
    check("stale_reqv", {63'h0, req_valid}, 64'h1);
    fetch(32'h91000421);
    check_ifid("tgt", 32'h91000421, 64'h100, 1'b1);
    check("tgt_addr", addr, 64'h104);

    req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("bp_reqv", {63'h0, req_valid}, 64'h1);
      check("bp_addr", addr, 64'h104);
      check("bp_pc", id_pc, 64'h100);
    end

    br     = 1'b1;
    br_tgt = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    br        = 1'b0;
    req_ready = 1'b1;
    check("br_req_addr", addr, 64'hFFFF_FFFF_FFFF_FFFC);
    check("br_req_reqv", {63'h0, req_valid}, 64'h1);
    fetch(32'h000000AA);
    check_ifid("wrap", 32'h000000AA, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1);
    check("wrap_addr", addr, 64'h0);

    tick();
    flush     = 1'b1;
    rsp_valid = 1'b1;
    rsp_data  = 32'h11;
    tick();
    rsp_valid = 1'b0;
    check_ifid("flrsp", 32'h11, 64'h0, 1'b1);
    tick();
    flush = 1'b0;
    check_ifid("fl", NOP, 64'h0, 1'b0);
    check("fl_addr", addr, 64'h4);
    rsp_valid = 1'b1;
    rsp_data  = 32'h22;
    tick();
    rsp_valid = 1'b0;
    check_ifid("flnext", 32'h22, 64'h4, 1'b1);

    req_ready = 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
    br     = 1'b1;
    br_tgt = 64'h102;
    tick();
    br = 1'b0;
    check_ifid("mis", NOP, 64'h102, 1'b1);
    check("mis_flag", {63'h0, id_mis}, 64'h1);
    for (int i = 0; i < 3; i++) begin
      check("mis_reqv", {63'h0, req_valid}, 64'h0);
      tick();
    end
    br     = 1'b1;
    br_tgt = 64'h200;
    tick();
    br = 1'b0;
    check("mis_clr", {63'h0, id_mis}, 64'h0);
    check("mis_addr", addr, 64'h200);
    check("mis_reqv1", {63'h0, req_valid}, 64'h1);
`else
    br     = 1'b1;
    br_tgt = 64'h203;
    tick();
    br = 1'b0;
    check("tgt_lsb_addr", addr, 64'h200);
    check("tgt_lsb_reqv", {63'h0, req_valid}, 64'h1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
